// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out of a 160x120, 3-bit framebuffer with 4x4 pixel replication.
// Define VGA_TEST_PATTERN_EN to replace framebuffer colour with eight 20-pixel-wide bars.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clock,
    input  logic        resetn,
    output logic [14:0] fb_addr,
    input  logic [2:0]  fb_rdata,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_start
);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_OFF = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic        tog_q, tog_d;
    logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
    logic [14:0] fb_addr_q, fb_addr_d;
    logic        hs1_q, hs1_d, vs1_q, vs1_d, blank1_q, blank1_d;
    logic        hs2_q, hs2_d, vs2_q, vs2_d, blank2_q, blank2_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        frame_start_q, frame_start_d;
    logic        pix_tick, visible;
    logic [7:0]  fx;
    logic [6:0]  fy;
    logic [2:0]  colour;

`ifdef VGA_TEST_PATTERN_EN
    logic [7:0] fx1_q, fx1_d;

    // Bar index is fx/20, built as a count of crossed thresholds.
    always_comb begin
        colour = 3'd0;
        for (int i = 1; i < 8; i++)
            if (fx1_q >= 8'(20 * i)) colour = colour + 3'd1;
    end
`else
    assign colour = fb_rdata;
`endif

    always_comb begin
        pix_tick      = tog_q;
        tog_d         = ~tog_q;
        fx            = hcount_q[9:2];
        fy            = vcount_q[8:2];
        visible       = (hcount_q < H_VIS) && (vcount_q < V_VIS);
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        fb_addr_d     = fb_addr_q;
        hs1_d         = hs1_q;
        vs1_d         = vs1_q;
        blank1_d      = blank1_q;
        hs2_d         = hs2_q;
        vs2_d         = vs2_q;
        blank2_d      = blank2_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        fx1_d         = fx1_q;
`endif
        if (pix_tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
            frame_start_d = (hcount_q == H_LAST) && (vcount_q == V_LAST);
            // fy*160 + fx; outside the visible area the last address is held.
            if (visible)
                fb_addr_d = {1'b0, fy, 7'd0} + {3'd0, fy, 5'd0} + {7'd0, fx};
            hs1_d    = !((hcount_q >= HS_ON) && (hcount_q < HS_OFF));
            vs1_d    = !((vcount_q >= VS_ON) && (vcount_q < VS_OFF));
            blank1_d = visible;
`ifdef VGA_TEST_PATTERN_EN
            fx1_d    = fx;
`endif
            // Memory data for the stage-1 address has had two clocks to settle.
            hs2_d    = hs1_q;
            vs2_d    = vs1_q;
            blank2_d = blank1_q;
            rgb_d    = blank1_q ? colour : 3'd0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tog_q         <= 1'b0;
            hcount_q      <= 10'd0;
            vcount_q      <= 10'd0;
            fb_addr_q     <= 15'd0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            blank1_q      <= 1'b0;
            hs2_q         <= 1'b1;
            vs2_q         <= 1'b1;
            blank2_q      <= 1'b0;
            rgb_q         <= 3'd0;
            frame_start_q <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            fx1_q         <= 8'd0;
`endif
        end else begin
            tog_q         <= tog_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            fb_addr_q     <= fb_addr_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            blank1_q      <= blank1_d;
            hs2_q         <= hs2_d;
            vs2_q         <= vs2_d;
            blank2_q      <= blank2_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_TEST_PATTERN_EN
            fx1_q         <= fx1_d;
`endif
        end
    end

    assign fb_addr     = fb_addr_q;
    assign VGA_R       = {8{rgb_q[2]}};
    assign VGA_G       = {8{rgb_q[1]}};
    assign VGA_B       = {8{rgb_q[0]}};
    assign VGA_HS      = hs2_q;
    assign VGA_VS      = vs2_q;
    assign VGA_BLANK_N = blank2_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = tog_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance and a shrunken-timing instance, both
// compared every clock against a position-arithmetic model, plus table and sequence checks.
module tb_vga_scanout;
    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic [14:0] fa_b, fa_s;
    logic [2:0]  rd_b = 3'd0, rd_s = 3'd0;
    logic [7:0]  r_b, g_b, b_b, r_s, g_s, b_s;
    logic        hs_b, vs_b, bl_b, sn_b, ck_b, fs_b;
    logic        hs_s, vs_s, bl_s, sn_s, ck_s, fs_s;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    vga_scanout dut_b (
        .clock(clock), .resetn(resetn), .fb_addr(fa_b), .fb_rdata(rd_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
        .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sn_b), .VGA_CLK(ck_b), .frame_start(fs_b)
    );

    vga_scanout #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)
    ) dut_s (
        .clock(clock), .resetn(resetn), .fb_addr(fa_s), .fb_rdata(rd_s),
        .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
        .VGA_BLANK_N(bl_s), .VGA_SYNC_N(sn_s), .VGA_CLK(ck_s), .frame_start(fs_s)
    );

    always #10 clock = ~clock;

    logic [2:0] mem_b [0:19199];
    logic [2:0] mem_s [0:19199];

    // One-clock-latency framebuffer memories.
    always @(posedge clock) begin
        rd_b <= mem_b[fa_b];
        rd_s <= mem_s[fa_s];
    end

    // Clock edges seen since reset was released.
    int n = 0;
    always @(posedge clock or negedge resetn)
        if (!resetn) n <= 0;
        else n <= n + 1;

    int checks = 0, errors = 0;
    bit run = 1'b0;

    typedef struct packed {
        logic [23:0] rgb;
        logic hs, vs, bl, sn, ck, fs;
        logic [14:0] addr;
    } obs_t;

    typedef struct {
        int h; int v;
        logic hs, vs, bl;
        logic [23:0] rgb, rgb_tp;
        logic [14:0] addr;
    } vec_t;

    function automatic int addr_of(input int h, input int v);
        return (v / 4) * 160 + h / 4;
    endfunction

    // Expected outputs after nn edges: k = nn/2 pixel ticks have happened, counters sit
    // at position k, fb_addr holds the last visible position < k, video shows position k-2.
    function automatic obs_t model(input int nn, input bit big);
        int hv, hf, hw, hb, vv, vf, vw, vb, ht, vt, tot, k, p, h, v;
        logic [2:0] c;
        obs_t o;
        if (big) begin
            hv = 640; hf = 16; hw = 96; hb = 48; vv = 480; vf = 10; vw = 2; vb = 33;
        end else begin
            hv = 16; hf = 4; hw = 8; hb = 4; vv = 8; vf = 2; vw = 2; vb = 4;
        end
        ht = hv + hf + hw + hb; vt = vv + vf + vw + vb; tot = ht * vt; k = nn / 2;
        o = '0; o.hs = 1'b1; o.vs = 1'b1;
        o.ck = (nn % 2) == 1;
        o.fs = (nn % 2 == 0) && (k >= 1) && ((k - 1) % tot == tot - 1);
        if (k >= 1) begin
            p = (k - 1) % tot; h = p % ht; v = p / ht;
            if (v >= vv)      o.addr = 15'(addr_of(hv - 1, vv - 1));
            else if (h >= hv) o.addr = 15'(addr_of(hv - 1, v));
            else              o.addr = 15'(addr_of(h, v));
        end
        if (k >= 2) begin
            p = (k - 2) % tot; h = p % ht; v = p / ht;
            o.hs = !(h >= hv + hf && h < hv + hf + hw);
            o.vs = !(v >= vv + vf && v < vv + vf + vw);
            o.bl = (h < hv) && (v < vv);
            if (o.bl) begin
                if (TP) c = 3'((h / 4) / 20);
                else    c = big ? mem_b[addr_of(h, v)] : mem_s[addr_of(h, v)];
                o.rgb = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
            end
        end
        return o;
    endfunction

    function automatic obs_t get_b();
        return {r_b, g_b, b_b, hs_b, vs_b, bl_b, sn_b, ck_b, fs_b, fa_b};
    endfunction
    function automatic obs_t get_s();
        return {r_s, g_s, b_s, hs_s, vs_s, bl_s, sn_s, ck_s, fs_s, fa_s};
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got %h want %h", name, n, got, exp);
        end
    endtask

    task automatic check_v(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    always @(negedge clock)
        if (run) begin
            check_obs("model_big", get_b(), model(n, 1'b1));
            check_obs("model_small", get_s(), model(n, 1'b0));
        end

    function automatic bit sig(input int sel);
        case (sel)
            0:       return hs_b;
            1:       return vs_s;
            2:       return fs_s;
            default: return hs_s;
        endcase
    endfunction

    // Waits for sig(sel) to change to lvl; w = negedges waited, -1 on timeout.
    task automatic wait_edge(input int sel, input bit lvl, input int bound, output int w);
        bit prev, cur;
        prev = sig(sel);
        w = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clock);
            cur = sig(sel);
            if (prev != lvl && cur == lvl) begin
                w = i;
                return;
            end
            prev = cur;
        end
        errors++;
        $display("FAIL edge_timeout sel=%0d got none want edge within %0d", sel, bound);
    endtask

    vec_t tbl [13];
    int w, w1, w2, g, tgt;

    initial begin
        for (int i = 0; i < 19200; i++) begin
            mem_b[i] = 3'(i);
            mem_s[i] = 3'($urandom);
        end
        tbl[0]  = '{0,   0, 1'b1, 1'b1, 1'b1, 24'h000000, 24'h000000, 15'd0};
        tbl[1]  = '{8,   0, 1'b1, 1'b1, 1'b1, 24'h00FF00, 24'h000000, 15'd2};
        tbl[2]  = '{80,  0, 1'b1, 1'b1, 1'b1, 24'hFF0000, 24'h0000FF, 15'd20};
        tbl[3]  = '{639, 0, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 15'd159};
        tbl[4]  = '{640, 0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000, 15'd159};
        tbl[5]  = '{655, 0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000, 15'd159};
        tbl[6]  = '{656, 0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000, 15'd159};
        tbl[7]  = '{751, 0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000, 15'd159};
        tbl[8]  = '{752, 0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000, 15'd159};
        tbl[9]  = '{799, 0, 1'b1, 1'b1, 1'b0, 24'h000000, 24'h000000, 15'd0};
        tbl[10] = '{3,   4, 1'b1, 1'b1, 1'b1, 24'h000000, 24'h000000, 15'd161};
        tbl[11] = '{4,   4, 1'b1, 1'b1, 1'b1, 24'h0000FF, 24'h000000, 15'd161};
        tbl[12] = '{400, 4, 1'b1, 1'b1, 1'b1, 24'hFF0000, 24'hFF00FF, 15'd260};

        #5 resetn = 1'b0;
        run = 1'b1;
        repeat (4) @(negedge clock);
        check_v("rst_ctl_big", {hs_b, vs_b, bl_b, ck_b, fs_b}, 5'b11000);
        check_v("rst_data_big", {r_b, g_b, b_b, fa_b}, 39'd0);
        check_v("rst_ctl_small", {hs_s, vs_s, bl_s, ck_s, fs_s}, 5'b11000);
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            tgt = 2 * (tbl[i].v * 800 + tbl[i].h + 2);
            g = 0;
            while (n != tgt && g < 20000) begin
                @(negedge clock);
                g++;
            end
            check_v($sformatf("tbl%0d_reached", i), n, tgt);
            check_v($sformatf("tbl%0d_sync", i), {hs_b, vs_b, bl_b},
                    {tbl[i].hs, tbl[i].vs, tbl[i].bl});
            check_v($sformatf("tbl%0d_rgb", i), {r_b, g_b, b_b}, TP ? tbl[i].rgb_tp : tbl[i].rgb);
            check_v($sformatf("tbl%0d_addr", i), fa_b, tbl[i].addr);
        end

        wait_edge(0, 1'b0, 4000, w);
        wait_edge(0, 1'b1, 4000, w1);
        check_v("hs_low_big", w1, 192);
        wait_edge(0, 1'b0, 4000, w2);
        check_v("hs_period_big", w1 + w2, 1600);

        wait_edge(3, 1'b0, 200, w);
        wait_edge(3, 1'b1, 200, w1);
        check_v("hs_low_small", w1, 16);
        wait_edge(3, 1'b0, 200, w2);
        check_v("hs_period_small", w1 + w2, 64);

        wait_edge(1, 1'b0, 3000, w);
        wait_edge(1, 1'b1, 3000, w1);
        check_v("vs_low_small", w1, 128);
        wait_edge(1, 1'b0, 3000, w2);
        check_v("vs_period_small", w1 + w2, 1024);

        wait_edge(2, 1'b1, 3000, w);
        wait_edge(2, 1'b1, 3000, w1);
        check_v("fs_period_small", w1, 1024);

        // Mid-frame reset at a random point, asserted between clock edges.
        repeat ($urandom_range(50, 1500)) @(negedge clock);
        #5 resetn = 1'b0;
        #1;
        check_v("midrst_ctl", {hs_b, vs_b, bl_b, hs_s, vs_s, bl_s}, 6'b110110);
        check_v("midrst_rgb", {r_b, g_b, b_b, r_s, g_s, b_s}, 48'd0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        wait_edge(3, 1'b0, 200, w);
        check_v("restart_hs_small", w, 44);
        wait_edge(0, 1'b0, 2000, w2);
        check_v("restart_hs_big", w + w2, 1316);

        repeat (1200) @(negedge clock);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
